// File: rtl/bpsk_frame_scheduler.sv
// Frame sequencer for the BPSK transmitter: preamble, sync word, length byte and payload.
// Each bit is held for one modulator symbol and advances on the modulator 'next' strobe.
module bpsk_frame_scheduler #(
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [31:0] SYNC_WORD     = 32'h0000_D391,
  parameter int          SYNC_BITS     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       abort,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       mod_next,
  output logic       mod_data,
  output logic       mod_enable,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int CNT_MAX = (PREAMBLE_BITS > SYNC_BITS) ?
                           ((PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8) :
                           ((SYNC_BITS > 8) ? SYNC_BITS : 8);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
  localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // Sync word left-justified so its first transmitted bit sits at bit 31.
  localparam logic [31:0] SYNC_ALIGNED = SYNC_WORD << (32 - SYNC_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_LENGTH,
    S_PAYLOAD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [31:0]      shift_q, shift_d;
  logic             mod_data_q, mod_data_d;
  logic             mod_enable_q, mod_enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       left_q, left_d;
  logic [7:0]       fetched_q, fetched_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             abort_q, abort_d;

  logic boundary;
  logic xfer;
  logic byte_boundary;
  logic finish_ok;
  logic go_idle;

  assign boundary   = mod_enable_q && mod_next;
  // No fetching during the preamble; the first payload byte is prefetched during SYNC.
  assign byte_ready = busy_q && !hold_full_q && (fetched_q < len_q) && !abort
                      && (state_q != S_PREAMBLE);
  assign xfer       = byte_valid && byte_ready;

  assign mod_data   = mod_data_q;
  assign mod_enable = mod_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign underrun   = underrun_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    mod_data_d    = mod_data_q;
    mod_enable_d  = mod_enable_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    underrun_d    = 1'b0;
    len_d         = len_q;
    left_d        = left_q;
    fetched_d     = fetched_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q || xfer;
    abort_d       = abort_q || (abort && (state_q != S_IDLE));
    byte_boundary = 1'b0;
    finish_ok     = 1'b0;
    go_idle       = 1'b0;

    if (xfer) begin
      hold_d    = byte_data;
      fetched_d = fetched_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_PREAMBLE;
          busy_d       = 1'b1;
          mod_enable_d = 1'b1;
          mod_data_d   = 1'b1;
          len_d        = len;
          bit_cnt_d    = '0;
          fetched_d    = 8'd0;
          left_d       = 8'd0;
        end
      end
      S_PREAMBLE: begin
        if (boundary) begin
          if (bit_cnt_q == PRE_LAST) begin
            state_d    = S_SYNC;
            mod_data_d = SYNC_ALIGNED[31];
            shift_d    = SYNC_ALIGNED << 1;
            bit_cnt_d  = '0;
          end else begin
            mod_data_d = !mod_data_q;
            bit_cnt_d  = bit_cnt_q + CNT_ONE;
          end
        end
      end
      S_SYNC: begin
        if (boundary) begin
          if (bit_cnt_q == SYNC_LAST) begin
            state_d    = S_LENGTH;
            mod_data_d = len_q[7];
            shift_d    = {len_q[6:0], 25'd0};
            bit_cnt_d  = '0;
          end else begin
            mod_data_d = shift_q[31];
            shift_d    = shift_q << 1;
            bit_cnt_d  = bit_cnt_q + CNT_ONE;
          end
        end
      end
      S_LENGTH, S_PAYLOAD: begin
        if (boundary) begin
          if (bit_cnt_q == BYTE_LAST) begin
            if ((state_q == S_LENGTH && len_q == 8'd0) ||
                (state_q == S_PAYLOAD && left_q == 8'd1)) begin
              finish_ok = 1'b1;
            end else begin
              byte_boundary = 1'b1;
            end
          end else begin
            mod_data_d = shift_q[31];
            shift_d    = shift_q << 1;
            bit_cnt_d  = bit_cnt_q + CNT_ONE;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase

    // Byte boundary consumes the old holding content; a same-cycle transfer refills it.
    if (byte_boundary) begin
      if (hold_full_q) begin
        state_d     = S_PAYLOAD;
        mod_data_d  = hold_q[7];
        shift_d     = {hold_q[6:0], 25'd0};
        bit_cnt_d   = '0;
        hold_full_d = xfer;
        left_d      = (state_q == S_LENGTH) ? len_q : (left_q - 8'd1);
      end else begin
        go_idle    = 1'b1;
        underrun_d = 1'b1;
      end
    end

    if (finish_ok) begin
      go_idle = 1'b1;
      done_d  = 1'b1;
    end

    // A latched abort pre-empts completion and underrun at the same boundary.
    if (abort_q && boundary) begin
      go_idle    = 1'b1;
      done_d     = 1'b0;
      underrun_d = 1'b0;
    end

    if (go_idle) begin
      state_d      = S_IDLE;
      bit_cnt_d    = '0;
      shift_d      = '0;
      mod_data_d   = 1'b0;
      mod_enable_d = 1'b0;
      busy_d       = 1'b0;
      len_d        = 8'd0;
      left_d       = 8'd0;
      fetched_d    = 8'd0;
      hold_d       = 8'd0;
      hold_full_d  = 1'b0;
      abort_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      mod_data_q   <= 1'b0;
      mod_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      len_q        <= 8'd0;
      left_q       <= 8'd0;
      fetched_q    <= 8'd0;
      hold_q       <= 8'd0;
      hold_full_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      mod_data_q   <= mod_data_d;
      mod_enable_q <= mod_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      len_q        <= len_d;
      left_q       <= left_d;
      fetched_q    <= fetched_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      abort_q      <= abort_d;
    end
  end

endmodule

// File: tb/tb_bpsk_frame_scheduler.sv
// Bench for bpsk_frame_scheduler: captures the transmitted bit per symbol and compares it
// with a bit stream built directly from the frame format.
module tb_bpsk_frame_scheduler;
  localparam int          PRE       = 4;
  localparam logic [31:0] SYNC_WORD = 32'h0000_D391;
  localparam int          SYNC_BITS = 16;

  logic       clk;
  logic       reset, start, abort, byte_valid, mod_next;
  logic [7:0] len, byte_data;
  logic       byte_ready, mod_data, mod_enable, busy, done, underrun;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         bnd_cyc = 0;
  int         glitch = 0;
  bit         rdy_seen = 0;
  bit         rx_q[$];
  bit         exp_q[$];
  logic [7:0] src_q[$];
  logic [7:0] pay[$];

  bpsk_frame_scheduler #(
    .PREAMBLE_BITS(PRE),
    .SYNC_WORD    (SYNC_WORD),
    .SYNC_BITS    (SYNC_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mod_next  (mod_next),
    .mod_data  (mod_data),
    .mod_enable(mod_enable),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modulator model: 8-cycle symbols, 'next' on the last cycle; records each completed bit.
  initial begin : modulator
    int  phase;
    bit  sym_bit;
    phase = 0;
    sym_bit = 0;
    mod_next = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mod_enable === 1'b1 && reset === 1'b0) begin
        if (phase == 0) sym_bit = mod_data;
        else if (mod_data !== sym_bit) glitch++;
        mod_next = (phase == 7);
        if (phase == 7) begin
          rx_q.push_back(mod_data);
          bnd_cyc = cyc;
        end
        phase = (phase + 1) % 8;
      end else begin
        mod_next = 1'b0;
        phase = 0;
      end
    end
  end

  // Byte source: presents src_q in order, always valid while it has bytes.
  initial begin : source
    bit xf;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    forever begin
      @(negedge clk);
      xf = (byte_valid === 1'b1) && (byte_ready === 1'b1) && (reset === 1'b0);
      if (byte_ready === 1'b1) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      if (xf && src_q.size() > 0) void'(src_q.pop_front());
      byte_valid = (src_q.size() > 0);
      byte_data  = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
    end
  end

  // Reference stream: alternating preamble, sync MSB first, length, then the bytes that can be sent.
  function automatic void build_exp(input logic [7:0] l, input int off, input int n);
    logic [31:0] sw;
    logic [7:0]  b;
    int          nsent;
    sw = SYNC_WORD;
    exp_q.delete();
    for (int i = 0; i < PRE; i++) exp_q.push_back(i % 2 == 0);
    for (int i = SYNC_BITS - 1; i >= 0; i--) exp_q.push_back(sw[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(l[i]);
    nsent = (n < int'(l)) ? n : int'(l);
    for (int k = 0; k < nsent; k++) begin
      b = pay[off + k];
      for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    end
  endfunction

  task automatic launch(input logic [7:0] l, input int n);
    src_q.delete();
    for (int k = 0; k < n; k++) src_q.push_back(pay[k]);
    build_exp(l, 0, n);
    rx_q.delete();
    rdy_seen = 1'b0;
    len = l;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out, output bit saw_done,
                           output bit saw_ur);
    timed_out = 1'b1;
    saw_done = 1'b0;
    saw_ur = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
      if (underrun === 1'b1) saw_ur = 1'b1;
      if (busy === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    len = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (mod_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b want 0", mod_enable); end
    n_vec++; if (mod_data !== 1'b0) begin n_err++; $display("FAIL reset_data: got %b want 0", mod_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if ({done, underrun, byte_ready} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {done, underrun, byte_ready}); end
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    bit          to, sd, su;
    logic [43:0] lit;
    lit = 44'b1010_1101001110010001_00000010_10100101_00111100;
    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    pay.delete();
    pay.push_back(8'hA5);
    pay.push_back(8'h3C);
    launch(8'd2, 2);
    n_vec++; if ({busy, mod_enable, mod_data} !== 3'b111) begin n_err++; $display("FAIL basic_start: got %b want 111", {busy, mod_enable, mod_data}); end
    wait_idle(2000, to, sd, su);
    n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout: busy stuck got 1 want 0"); end
    n_vec++; if (done !== 1'b1 || su) begin n_err++; $display("FAIL basic_done: got done=%b ur=%b want 1/0", done, su); end
    n_vec++; if (cyc - bnd_cyc != 1) begin n_err++; $display("FAIL basic_latency: got %0d want 1", cyc - bnd_cyc); end
    n_vec++; if ({mod_enable, mod_data} !== 2'b00) begin n_err++; $display("FAIL basic_end_out: got %b want 00", {mod_enable, mod_data}); end
    n_vec++;
    if (rx_q.size() != 44) begin n_err++; $display("FAIL basic_len: got %0d bits want 44", rx_q.size()); end
    else for (int i = 0; i < 44; i++) begin
      n_vec++;
      if (rx_q[i] !== lit[43 - i] || rx_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL basic_bit%0d: got %b want %b", i, rx_q[i], lit[43 - i]); break;
      end
    end
    @(posedge clk);
    #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    $display("basic: len=2 frame, %0d bits", rx_q.size());
  endtask

  task automatic test_len_zero();
    bit to, sd, su;
    pay.delete();
    pay.push_back(8'($urandom));
    launch(8'd0, 1);
    wait_idle(2000, to, sd, su);
    n_vec++; if (to || !sd || su) begin n_err++; $display("FAIL len0_end: got to=%b done=%b ur=%b want 0/1/0", to, sd, su); end
    n_vec++; if (rdy_seen) begin n_err++; $display("FAIL len0_ready: got byte_ready=1 want never"); end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL len0_len: got %0d bits want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL len0_bit%0d: got %b want %b", i, rx_q[i], exp_q[i]); break; end
    end
    @(posedge clk);
    #1;
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL len0_after: got %b want 00", {busy, done}); end
    $display("len_zero: %0d bits", rx_q.size());
  endtask

  task automatic test_underrun();
    bit to, sd, su;
    pay.delete();
    repeat (3) pay.push_back(8'($urandom));
    launch(8'd3, 1);
    wait_idle(2000, to, sd, su);
    n_vec++; if (to || sd || underrun !== 1'b1) begin n_err++; $display("FAIL ur_end: got to=%b done=%b ur=%b want 0/0/1", to, sd, underrun); end
    n_vec++; if (cyc - bnd_cyc != 1) begin n_err++; $display("FAIL ur_latency: got %0d want 1", cyc - bnd_cyc); end
    n_vec++; if ({mod_enable, mod_data} !== 2'b00) begin n_err++; $display("FAIL ur_out: got %b want 00", {mod_enable, mod_data}); end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL ur_len: got %0d bits want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ur_bit%0d: got %b want %b", i, rx_q[i], exp_q[i]); break; end
    end
    @(posedge clk);
    #1;
    n_vec++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_width: got %b want 0", underrun); end
    $display("underrun: %0d bits before underrun", rx_q.size());
  endtask

  task automatic test_abort();
    bit to, sd, su;
    int want;
    pay.delete();
    repeat (3) pay.push_back(8'($urandom));
    launch(8'd3, 3);
    for (int i = 0; i < 2000 && rx_q.size() < PRE + 5; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    wait_idle(2000, to, sd, su);
    want = PRE + 6;
    n_vec++; if (to || sd || su) begin n_err++; $display("FAIL abort_end: got to=%b done=%b ur=%b want 0/0/0", to, sd, su); end
    n_vec++; if ({mod_enable, mod_data, byte_ready} !== 3'b000) begin n_err++; $display("FAIL abort_out: got %b want 000", {mod_enable, mod_data, byte_ready}); end
    n_vec++;
    if (rx_q.size() != want) begin n_err++; $display("FAIL abort_len: got %0d bits want %0d", rx_q.size(), want); end
    else for (int i = 0; i < want; i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_bit%0d: got %b want %b", i, rx_q[i], exp_q[i]); break; end
    end
    $display("abort: stopped after %0d bits", rx_q.size());
    repeat (4) @(posedge clk);
    #1;
    pay.delete();
    repeat (2) pay.push_back(8'($urandom));
    launch(8'd2, 2);
    wait_idle(2000, to, sd, su);
    n_vec++; if (to || !sd || su) begin n_err++; $display("FAIL abort_next_end: got to=%b done=%b ur=%b want 0/1/0", to, sd, su); end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL abort_next_len: got %0d bits want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_next_bit%0d: got %b want %b", i, rx_q[i], exp_q[i]); break; end
    end
    $display("abort: clean frame afterwards, %0d bits", rx_q.size());
  endtask

  task automatic test_back_to_back();
    bit to, sd, su, relaunched;
    pay.delete();
    repeat (4) pay.push_back(8'($urandom));
    src_q = pay;
    build_exp(8'd2, 0, 2);
    rx_q.delete();
    len = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_start: got %b want 1", busy); end
    wait_idle(2000, to, sd, su);
    n_vec++; if (to || !sd || su) begin n_err++; $display("FAIL b2b_first_end: got to=%b done=%b ur=%b want 0/1/0", to, sd, su); end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_first_len: got %0d bits want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_first_bit%0d: got %b want %b", i, rx_q[i], exp_q[i]); break; end
    end
    build_exp(8'd2, 2, 2);
    rx_q.delete();
    @(posedge clk);
    #1;
    start = 1'b0;
    n_vec++; if ({busy, mod_enable, mod_data} !== 3'b111) begin n_err++; $display("FAIL b2b_restart: got %b want 111", {busy, mod_enable, mod_data}); end
    wait_idle(2000, to, sd, su);
    n_vec++; if (to || !sd || su) begin n_err++; $display("FAIL b2b_second_end: got to=%b done=%b ur=%b want 0/1/0", to, sd, su); end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_second_len: got %0d bits want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_second_bit%0d: got %b want %b", i, rx_q[i], exp_q[i]); break; end
    end
    relaunched = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) relaunched = 1'b1;
    end
    n_vec++; if (relaunched) begin n_err++; $display("FAIL b2b_extra_frame: got busy=1 want 0"); end
    $display("back_to_back: two frames from one held start");
  endtask

  task automatic test_reset_mid();
    bit to, sd, su;
    pay.delete();
    repeat (3) pay.push_back(8'($urandom));
    launch(8'd3, 3);
    for (int i = 0; i < 2000 && rx_q.size() < PRE + SYNC_BITS + 8 + 3; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_vec++; if ({busy, mod_enable, mod_data, done, underrun, byte_ready} !== 6'b0)
      begin n_err++; $display("FAIL rstmid_out: got %b want 000000", {busy, mod_enable, mod_data, done, underrun, byte_ready}); end
    @(posedge clk);
    #1;
    pay.delete();
    pay.push_back(8'($urandom));
    launch(8'd1, 1);
    wait_idle(2000, to, sd, su);
    n_vec++; if (to || !sd || su) begin n_err++; $display("FAIL rstmid_next_end: got to=%b done=%b ur=%b want 0/1/0", to, sd, su); end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_len: got %0d bits want %0d", rx_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_bit%0d: got %b want %b", i, rx_q[i], exp_q[i]); break; end
    end
    $display("reset_mid: recovery frame %0d bits", rx_q.size());
  endtask

  task automatic test_random();
    bit         to, sd, su;
    logic [7:0] l;
    int         n;
    for (int f = 0; f < 8; f++) begin
      l = 8'($urandom_range(0, 6));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : int'(l);
      pay.delete();
      for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
      launch(l, n);
      wait_idle(2000, to, sd, su);
      n_vec++;
      if (to || sd !== (n >= int'(l)) || su !== (n < int'(l))) begin
        n_err++; $display("FAIL rand%0d_end: got to=%b done=%b ur=%b want 0/%b/%b", f, to, sd, su, n >= int'(l), n < int'(l));
      end
      n_vec++;
      if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_len: got %0d bits want %0d", f, rx_q.size(), exp_q.size()); end
      else for (int i = 0; i < exp_q.size(); i++) begin
        n_vec++;
        if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_bit%0d: got %b want %b", f, i, rx_q[i], exp_q[i]); break; end
      end
      $display("random frame %0d: len=%0d bytes=%0d bits=%0d done=%b underrun=%b", f, l, n, rx_q.size(), sd, su);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    len = 8'd0;
    test_reset();
    test_basic();
    test_len_zero();
    test_underrun();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_vec++; if (glitch != 0) begin n_err++; $display("FAIL symbol_hold: got %0d mid-symbol changes want 0", glitch); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
